odo_nonce_collector: RTL and testbench



---
 rtl/odo_nonce_collector.sv | 202 ++++++++++++++++++++
 tb/tb_odo_nonce_collector.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/odo_nonce_collector.sv
// odo_nonce_collector
//   Qualifies golden-nonce hits from the Odocrypt core and queues them for the
//   USB3 interface. Hits are ignored for BLANK_CYCLES cycles after a job
//   starts, while the core pipeline is still filling. Accepted hits pass
//   through a one-cycle capture stage into a DEPTH-entry FIFO. The FIFO head
//   is presented on nonce_valid/nonce_out until it is acknowledged.
//   The collector flushes when start_hash falls or host_break pulses.
//
// Handshake: nonce_valid/nonce_out hold the FIFO head. The head is popped on
//   any rising clk_h edge where nonce_valid=1 and nonce_ack=1. The next head,
//   or nonce_valid=0, is visible after that same edge. nonce_ack is ignored
//   while nonce_valid=0. nonce_out keeps its last value while the FIFO is
//   empty.
//
// Optional build macro ODO_NONCE_DEDUP_EN: when defined, a hit repeating the
//   last accepted nonce is dropped. This collapses a core that holds
//   ticket2moon high into a single FIFO entry.
//
// Ports:
//   clk_h        in   hashing clock, rising edge
//   rst          in   synchronous reset, active-high
//   start_hash   in   job-active level
//   host_break   in   single-cycle abort pulse
//   ticket2moon  in   raw hit flag from the core
//   nonce[31:0]  in   golden nonce, valid while ticket2moon=1
//   nonce_valid  out  FIFO head valid
//   nonce_out    out  FIFO head value
//   nonce_ack    in   pop request
//   fifo_count   out  entries held, 0..DEPTH
//   overflow     out  sticky: a qualified hit was dropped on a full FIFO
//   state_dbg    out  FSM state (0 IDLE, 1 BLANK, 2 RUN, 3 FLUSH)
module odo_nonce_collector #(
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter int BLANK_CYCLES = 205
) (
  input  logic          clk_h,
  input  logic          rst,
  input  logic          start_hash,
  input  logic          host_break,
  input  logic          ticket2moon,
  input  logic [31:0]   nonce,
  output logic          nonce_valid,
  output logic [31:0]   nonce_out,
  input  logic          nonce_ack,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [7:0] BLANK_INIT = 8'(BLANK_CYCLES);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic            start_d;
  logic            rearm_q;
  logic [7:0]      blank_cnt_q;
  logic            cap_valid_q;
  logic [31:0]     cap_nonce_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_n;
  logic [31:0]     mem [DEPTH];
  logic [AW:0]     count_n;
  logic            valid_n;
  logic [31:0]     head_n;

  logic start_rise, start_fall, in_job, flush_req, enter_blank;
  logic hit, fifo_clear, wr, rd, full, wr_eff, drop;

  // rearm_q blocks a "rise" from a start_hash that was already high when
  // reset was released. A job starts only after start_hash is seen low.
  assign start_rise  = start_hash & ~start_d & ~rearm_q;
  assign start_fall  = ~start_hash & start_d;
  assign in_job      = (state_q == S_BLANK) || (state_q == S_RUN);
  assign flush_req   = in_job & (host_break | start_fall);
  assign enter_blank = (state_d == S_BLANK) && (state_q != S_BLANK);
  assign state_dbg   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_rise) state_d = S_BLANK;
      S_BLANK: begin
        if (flush_req)              state_d = S_FLUSH;
        else if (blank_cnt_q == 8'd1) state_d = S_RUN;
      end
      S_RUN:   if (flush_req) state_d = S_FLUSH;
      S_FLUSH: state_d = start_rise ? S_BLANK : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_h) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_d     <= 1'b0;
      rearm_q     <= 1'b1;
      blank_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      start_d <= start_hash;
      if (!start_hash) rearm_q <= 1'b0;
      if (enter_blank)
        blank_cnt_q <= BLANK_INIT;
      else if (state_q == S_BLANK && blank_cnt_q != 8'd0)
        blank_cnt_q <= blank_cnt_q - 8'd1;
    end
  end

  // Hit qualification. A flush request in the same cycle wins over the hit.
`ifdef ODO_NONCE_DEDUP_EN
  logic [31:0] last_nonce_q;
  logic        last_valid_q;
  logic        repeat_hit;

  assign repeat_hit = last_valid_q && (nonce == last_nonce_q);
  assign hit = (state_q == S_RUN) & ticket2moon & ~flush_req & ~repeat_hit;

  always_ff @(posedge clk_h) begin
    if (rst) begin
      last_nonce_q <= 32'h0;
      last_valid_q <= 1'b0;
    end else if (enter_blank || flush_req || state_q == S_FLUSH) begin
      last_valid_q <= 1'b0;
    end else if (hit) begin
      last_nonce_q <= nonce;
      last_valid_q <= 1'b1;
    end
  end
`else
  assign hit = (state_q == S_RUN) & ticket2moon & ~flush_req;
`endif

  // The FIFO clears on the edge that detects the flush and again in FLUSH.
  // The capture stage is discarded by the same clear.
  assign fifo_clear = flush_req | (state_q == S_FLUSH);
  assign wr         = cap_valid_q & ~fifo_clear;
  assign rd         = nonce_valid & nonce_ack & ~fifo_clear;
  assign full       = (fifo_count == FULL_CNT);
  assign wr_eff     = wr & (~full | rd);
  assign drop       = wr & full & ~rd;

  always_ff @(posedge clk_h) begin
    if (rst) begin
      cap_valid_q <= 1'b0;
      cap_nonce_q <= 32'h0;
    end else begin
      cap_valid_q <= hit;
      if (hit) cap_nonce_q <= nonce;
    end
  end

  // Next head. When the slot becoming head is the one being written on this
  // edge, take the capture value directly, because mem does not hold it yet.
  always_comb begin
    count_n  = fifo_count;
    rd_ptr_n = rd_ptr_q;
    valid_n  = nonce_valid;
    head_n   = nonce_out;
    if (fifo_clear) begin
      count_n  = '0;
      rd_ptr_n = '0;
      valid_n  = 1'b0;
    end else begin
      count_n  = fifo_count + (AW+1)'(wr_eff) - (AW+1)'(rd);
      rd_ptr_n = rd_ptr_q + AW'(rd);
      valid_n  = (count_n != '0);
      if (valid_n)
        head_n = (wr_eff && rd_ptr_n == wr_ptr_q) ? cap_nonce_q : mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk_h) begin
    if (wr_eff) mem[wr_ptr_q] <= cap_nonce_q;
  end

  always_ff @(posedge clk_h) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_count  <= '0;
      nonce_valid <= 1'b0;
      nonce_out   <= 32'h0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr_q    <= fifo_clear ? '0 : wr_ptr_q + AW'(wr_eff);
      rd_ptr_q    <= rd_ptr_n;
      fifo_count  <= count_n;
      nonce_valid <= valid_n;
      nonce_out   <= head_n;
      if (enter_blank) overflow <= 1'b0;
      else if (drop)   overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_odo_nonce_collector.sv
module tb_odo_nonce_collector;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int BLANK = 205;
  localparam logic [1:0] S_IDLE = 2'd0, S_BLANK = 2'd1, S_RUN = 2'd2, S_FLUSH = 2'd3;

  logic          clk_h = 1'b0;
  logic          rst, start_hash, host_break, ticket2moon, nonce_ack;
  logic [31:0]   nonce;
  logic          nonce_valid, overflow;
  logic [31:0]   nonce_out;
  logic [AW:0]   fifo_count;
  logic [1:0]    state_dbg;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk_h = ~clk_h;

  odo_nonce_collector #(.DEPTH(DEPTH), .AW(AW), .BLANK_CYCLES(BLANK)) dut (
    .clk_h(clk_h), .rst(rst), .start_hash(start_hash), .host_break(host_break),
    .ticket2moon(ticket2moon), .nonce(nonce), .nonce_valid(nonce_valid),
    .nonce_out(nonce_out), .nonce_ack(nonce_ack), .fifo_count(fifo_count),
    .overflow(overflow), .state_dbg(state_dbg)
  );

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  // driver tasks
  task automatic drive_hit(input logic [31:0] n, input bit expect_accept);
    ticket2moon = 1'b1;
    nonce = n;
    if (expect_accept) exp_q.push_back(n);
    tick();
    ticket2moon = 1'b0;
  endtask

  task automatic start_job();
    start_hash = 1'b1;
    tick();
    repeat (BLANK) tick();
    checks++;
    if (state_dbg !== S_RUN) begin
      errors++;
      $display("FAIL start_job_run: state=%0d expected=%0d", state_dbg, S_RUN);
    end
  endtask

  task automatic end_job();
    start_hash = 1'b0;
    tick();
    tick();
    exp_q.delete();
    checks++;
    if (state_dbg !== S_IDLE || fifo_count !== 0) begin
      errors++;
      $display("FAIL end_job: state=%0d count=%0d expected state=0 count=0", state_dbg, fifo_count);
    end
  endtask

  // Acks n entries back to back and checks each head against the scoreboard.
  task automatic drain(input int n, input string tag);
    nonce_ack = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) exp_v = 32'hxxxxxxxx;
      else exp_v = exp_q.pop_front();
      checks++;
      if (nonce_valid !== 1'b1 || nonce_out !== exp_v) begin
        errors++;
        $display("FAIL %s_pop%0d: valid=%b out=%h expected valid=1 out=%h", tag, i, nonce_valid, nonce_out, exp_v);
      end
      tick();
    end
    nonce_ack = 1'b0;
    checks++;
    if (nonce_valid !== 1'b0 || fifo_count !== 0) begin
      errors++;
      $display("FAIL %s_empty: valid=%b count=%0d expected valid=0 count=0", tag, nonce_valid, fifo_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_hash = 0; host_break = 0; ticket2moon = 0; nonce_ack = 0; nonce = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (nonce_valid !== 0 || nonce_out !== 32'h0 || fifo_count !== 0 || overflow !== 0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset: valid=%b out=%h count=%0d ovf=%b state=%0d expected all zero",
               nonce_valid, nonce_out, fifo_count, overflow, state_dbg);
    end
  endtask

  task automatic test_idle_ignores();
    nonce_ack = 1'b1;
    host_break = 1'b1;
    tick();
    nonce_ack = 1'b0;
    host_break = 1'b0;
    tick();
    checks++;
    if (state_dbg !== S_IDLE || fifo_count !== 0 || nonce_valid !== 0) begin
      errors++;
      $display("FAIL idle_ignores: state=%0d count=%0d valid=%b expected 0/0/0", state_dbg, fifo_count, nonce_valid);
    end
  endtask

  task automatic test_blanking();
    start_hash = 1'b1;
    tick();                           // now cycle 1
    checks++;
    if (state_dbg !== S_BLANK) begin
      errors++;
      $display("FAIL blank_entry: state=%0d expected=%0d", state_dbg, S_BLANK);
    end
    repeat (99) tick();               // cycle 100
    drive_hit(32'h11111111, 1'b0);    // cycle 101
    repeat (104) tick();              // cycle 205
    checks++;
    if (state_dbg !== S_BLANK) begin
      errors++;
      $display("FAIL blank_last: state=%0d expected=%0d", state_dbg, S_BLANK);
    end
    tick();                           // cycle 206
    checks++;
    if (state_dbg !== S_RUN) begin
      errors++;
      $display("FAIL blank_to_run: state=%0d expected=%0d", state_dbg, S_RUN);
    end
    repeat (4) tick();                // cycle 210
    drive_hit(32'h22222222, 1'b1);    // cycle 211
    checks++;
    if (nonce_valid !== 0 || fifo_count !== 0) begin
      errors++;
      $display("FAIL blank_latency1: valid=%b count=%0d expected valid=0 count=0", nonce_valid, fifo_count);
    end
    tick();                           // cycle 212
    checks++;
    if (nonce_valid !== 1 || nonce_out !== 32'h22222222 || fifo_count !== 1) begin
      errors++;
      $display("FAIL blank_latency2: valid=%b out=%h count=%0d expected valid=1 out=22222222 count=1",
               nonce_valid, nonce_out, fifo_count);
    end
    drain(1, "blank");
    end_job();
  endtask

  task automatic test_fill_overflow();
    logic [31:0] n;
    start_job();
    for (int i = 0; i < 9; i++) begin
      n = ($urandom_range(0, 16'hFFFF) << 8) | 32'(i);
      drive_hit(n, i < 8);
    end
    tick();
    tick();
    checks++;
    if (fifo_count !== 4'(DEPTH) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill: count=%0d ovf=%b expected count=8 ovf=1", fifo_count, overflow);
    end
    drain(8, "fill");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b expected=1", overflow);
    end
  endtask

  // Continues the job left open by test_fill_overflow, with overflow set.
  task automatic test_abort();
    logic [31:0] n;
    for (int i = 0; i < 3; i++) begin
      n = ($urandom_range(0, 16'hFFFF) << 8) | 32'(8'h80 + i);
      drive_hit(n, 1'b1);
    end
    tick();
    tick();
    checks++;
    if (fifo_count !== 3) begin
      errors++;
      $display("FAIL abort_pre: count=%0d expected=3", fifo_count);
    end
    host_break = 1'b1;
    drive_hit(32'hABCD0001, 1'b0);
    host_break = 1'b0;
    exp_q.delete();
    checks++;
    if (fifo_count !== 0 || nonce_valid !== 0 || state_dbg !== S_FLUSH || overflow !== 1) begin
      errors++;
      $display("FAIL abort_flush: count=%0d valid=%b state=%0d ovf=%b expected 0/0/3/1",
               fifo_count, nonce_valid, state_dbg, overflow);
    end
    tick();
    checks++;
    if (state_dbg !== S_IDLE || fifo_count !== 0) begin
      errors++;
      $display("FAIL abort_idle: state=%0d count=%0d expected 0/0", state_dbg, fifo_count);
    end
    repeat (3) tick();
    checks++;
    if (state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL abort_no_restart: state=%0d expected=0", state_dbg);
    end
    start_hash = 1'b0;
    tick();
    start_hash = 1'b1;
    tick();                             // cycle 1 of new blank window
    checks++;
    if (state_dbg !== S_BLANK || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reblank: state=%0d ovf=%b expected state=1 ovf=0", state_dbg, overflow);
    end
    drive_hit(32'h33333333, 1'b0);       // cycle 2
    repeat (203) tick();                // cycle 205
    checks++;
    if (state_dbg !== S_BLANK || fifo_count !== 0) begin
      errors++;
      $display("FAIL reblank_last: state=%0d count=%0d expected state=1 count=0", state_dbg, fifo_count);
    end
    tick();
    checks++;
    if (state_dbg !== S_RUN) begin
      errors++;
      $display("FAIL reblank_run: state=%0d expected=%0d", state_dbg, S_RUN);
    end
    end_job();
  endtask

  task automatic test_full_push_pop();
    logic [31:0] n;
    start_job();
    for (int i = 0; i < DEPTH; i++) begin
      n = ($urandom_range(0, 16'hFFFF) << 8) | 32'(8'h40 + i);
      drive_hit(n, 1'b1);
    end
    tick();
    tick();
    checks++;
    if (fifo_count !== 4'(DEPTH) || overflow !== 0) begin
      errors++;
      $display("FAIL full_pre: count=%0d ovf=%b expected count=8 ovf=0", fifo_count, overflow);
    end
    // The captured hit reaches the FIFO on the same edge as the pop.
    drive_hit(32'h5A5A0099, 1'b1);
    nonce_ack = 1'b1;
    exp_v = exp_q.pop_front();
    checks++;
    if (nonce_out !== exp_v) begin
      errors++;
      $display("FAIL full_pop_head: out=%h expected=%h", nonce_out, exp_v);
    end
    tick();
    nonce_ack = 1'b0;
    checks++;
    if (fifo_count !== 4'(DEPTH) || overflow !== 0) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d ovf=%b expected count=8 ovf=0", fifo_count, overflow);
    end
    drain(DEPTH, "full");
    end_job();
  endtask

  task automatic test_dedup();
    int exp_cnt;
    start_job();
`ifdef ODO_NONCE_DEDUP_EN
    exp_cnt = 2;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h00000001);
`else
    exp_cnt = 5;
    repeat (4) exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h00000001);
`endif
    ticket2moon = 1'b1;
    nonce = 32'hDEADBEEF;
    repeat (4) tick();
    nonce = 32'h00000001;
    tick();
    ticket2moon = 1'b0;
    tick();
    tick();
    checks++;
    if (fifo_count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL dedup_count: count=%0d expected=%0d", fifo_count, exp_cnt);
    end
    drain(exp_cnt, "dedup");
    end_job();
  endtask

  task automatic test_reset_mid_run();
    start_job();
    for (int i = 0; i < 5; i++) drive_hit(32'h70000000 | 32'(i), 1'b1);
    tick();
    tick();
    checks++;
    if (fifo_count !== 5 || nonce_valid !== 1) begin
      errors++;
      $display("FAIL rst_pre: count=%0d valid=%b expected count=5 valid=1", fifo_count, nonce_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (nonce_valid !== 0 || nonce_out !== 32'h0 || fifo_count !== 0 || overflow !== 0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL rst_mid: valid=%b out=%h count=%0d ovf=%b state=%0d expected all zero",
               nonce_valid, nonce_out, fifo_count, overflow, state_dbg);
    end
    repeat (5) tick();
    checks++;
    if (state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL rst_no_restart: state=%0d expected=0", state_dbg);
    end
    start_hash = 1'b0;
    tick();
    start_hash = 1'b1;
    tick();
    checks++;
    if (state_dbg !== S_BLANK) begin
      errors++;
      $display("FAIL rst_restart: state=%0d expected=%0d", state_dbg, S_BLANK);
    end
    end_job();
  endtask

  initial begin
    test_reset();
    test_idle_ignores();
    test_blanking();
    test_fill_overflow();
    test_abort();
    test_full_push_pop();
    test_dedup();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
